// File: rtl/spi_master_cfg_if.sv
// Control-bus interface for spi_master_cfg.
// data_in/address/we/sel come from the bus master; data_out (combinational
// read data) and interrupt are returned by the SPI master block.
interface spi_master_cfg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 3
);
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic [ADDR_W-1:0] address;
   logic              we;
   logic              sel;
   logic              interrupt;

   modport master (output data_in, address, we, sel, input data_out, interrupt);
   modport slave  (input data_in, address, we, sel, output data_out, interrupt);
endinterface

// File: rtl/spi_master_cfg.sv
// Register-programmable SPI master.
// Ports: clk, ctr_nrst (async active-low reset); sclk/ss/mosi/miso SPI pins;
// bus: control interface (data_in, data_out, address, we, sel, interrupt).
// Map: 0 int_en(W) 1 status(R) 2 tx(W, starts) 3 rx(R) 4 config 5 div 6 len.
module spi_master_cfg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned N_SS   = 4,
   parameter int unsigned DIV_W  = 8
) (
   input  logic            clk,
   input  logic            ctr_nrst,
   output logic            sclk,
   output logic [N_SS-1:0] ss,
   output logic            mosi,
   input  logic            miso,
   spi_master_cfg_if.slave bus
);
   localparam int unsigned LEN_W  = $clog2(DATA_W);
   localparam int unsigned SS_W   = (N_SS > 1) ? $clog2(N_SS) : 1;
   localparam int unsigned CFG_W  = 3 + SS_W;
   localparam int unsigned EDGE_W = LEN_W + 2;

   localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_LEN  = ADDR_W'(6);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state, state_next;
   logic [DIV_W-1:0]  cnt, div_q;
   logic [EDGE_W-1:0] edges, n_edges;
   logic [LEN_W-1:0]  len_q, tx_cnt, rx_cnt, tx_pos, rx_pos, first_pos;
   logic [CFG_W-1:0]  cfg_q;
   logic [SS_W-1:0]   ss_idx;
   logic [DATA_W-1:0] tx_q, rx_q;
   logic int_en, ready, err;
   logic cpha, cpol, lsb;
   logic busy, tick, done, last_edge, sample, shift;
   logic wr, rd, wr_ien, wr_tx, wr_cfg, wr_div, wr_len, rd_stat, rd_rx, start;

   assign cpha   = cfg_q[0];
   assign cpol   = cfg_q[1];
   assign lsb    = cfg_q[2];
   assign ss_idx = cfg_q[3 +: SS_W];

   assign wr      = bus.sel & bus.we;
   assign rd      = bus.sel & ~bus.we;
   assign wr_ien  = wr && (bus.address == A_IEN);
   assign wr_tx   = wr && (bus.address == A_TX);
   assign wr_cfg  = wr && (bus.address == A_CFG);
   assign wr_div  = wr && (bus.address == A_DIV);
   assign wr_len  = wr && (bus.address == A_LEN);
   assign rd_stat = rd && (bus.address == A_STAT);
   assign rd_rx   = rd && (bus.address == A_RX);

   assign busy  = (state != IDLE);
   assign start = wr_tx && !busy;
   // One tick per half-period: counter runs 0..DIV, tick on the terminal count
   assign tick  = (cnt == div_q);
   assign done  = (state == HOLD) && tick;

   // Edge bookkeeping: edges holds the number of sclk edges already produced
   assign n_edges   = (EDGE_W'(len_q) + EDGE_W'(1)) << 1;
   assign last_edge = ((edges + EDGE_W'(1)) == n_edges);
   // Upcoming edge is odd when the count so far is even
   assign sample    = ~edges[0] ^ cpha;
   assign shift     = ~sample & ~last_edge;

   // Bit position inside tx/rx for the n-th bit in transmit order
   assign tx_pos    = lsb ? tx_cnt : len_q - tx_cnt;
   assign rx_pos    = lsb ? rx_cnt : len_q - rx_cnt;
   assign first_pos = lsb ? '0 : len_q;

   // FSM state register
   always_ff @(posedge clk or negedge ctr_nrst) begin
      if (!ctr_nrst) state <= IDLE;
      else           state <= state_next;
   end

   // FSM next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)             state_next = SETUP;
         SETUP:   if (tick)              state_next = XFER;
         XFER:    if (tick && last_edge) state_next = HOLD;
         HOLD:    if (tick)              state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   // Registers, divider and shift datapath
   always_ff @(posedge clk or negedge ctr_nrst) begin
      if (!ctr_nrst) begin
         int_en <= 1'b0;
         cfg_q  <= '0;
         div_q  <= '0;
         len_q  <= LEN_W'(DATA_W - 1);
         ready  <= 1'b0;
         err    <= 1'b0;
         tx_q   <= '0;
         rx_q   <= '0;
         cnt    <= '0;
         edges  <= '0;
         tx_cnt <= '0;
         rx_cnt <= '0;
         ss     <= '1;
         sclk   <= 1'b0;
         mosi   <= 1'b0;
      end else begin
         if (wr_ien)          int_en <= bus.data_in[0];
         if (wr_cfg && !busy) cfg_q  <= bus.data_in[CFG_W-1:0];
         if (wr_div && !busy) div_q  <= bus.data_in[DIV_W-1:0];
         if (wr_len && !busy) len_q  <= bus.data_in[LEN_W-1:0];

         if (wr_tx && busy) err <= 1'b1;
         else if (rd_stat)  err <= 1'b0;

         // Start beats any same-cycle rx read
         if (start)      ready <= 1'b0;
         else if (done)  ready <= 1'b1;
         else if (rd_rx) ready <= 1'b0;

         if (start) begin
            tx_q   <= bus.data_in;
            rx_q   <= '0;
            cnt    <= '0;
            edges  <= '0;
            rx_cnt <= '0;
            ss     <= ~(N_SS'(1) << ss_idx);
            sclk   <= cpol;
            if (cpha) begin
               mosi   <= 1'b0;
               tx_cnt <= '0;
            end else begin
               mosi   <= bus.data_in[first_pos];
               tx_cnt <= LEN_W'(1);
            end
         end else if (!busy) begin
            // Idle level tracks CPOL, including a config write this cycle
            sclk <= wr_cfg ? bus.data_in[1] : cpol;
            mosi <= 1'b0;
         end else begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick) begin
               if (state == HOLD) begin
                  ss   <= '1;
                  mosi <= 1'b0;
               end else begin
                  sclk  <= ~sclk;
                  edges <= edges + EDGE_W'(1);
                  if (sample) begin
                     rx_q[rx_pos] <= miso;
                     rx_cnt       <= rx_cnt + LEN_W'(1);
                  end
                  if (shift) begin
                     mosi   <= tx_q[tx_pos];
                     tx_cnt <= tx_cnt + LEN_W'(1);
                  end
               end
            end
         end
      end
   end

   // Combinational read mux
   always_comb begin
      bus.data_out = '0;
      case (bus.address)
         A_STAT:  bus.data_out = DATA_W'({err, busy, ready});
         A_RX:    bus.data_out = rx_q;
         A_CFG:   bus.data_out = DATA_W'(cfg_q);
         A_DIV:   bus.data_out = DATA_W'(div_q);
         A_LEN:   bus.data_out = DATA_W'(len_q);
         default: bus.data_out = '0;
      endcase
   end

   assign bus.interrupt = int_en & ready;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: directed vector table, hand-written
// corner sequences and randomized transfers against a timing/bit-order model.
module tb_spi_master_cfg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   localparam int N_SS   = 4;
   localparam int MAXT   = 17000;

   logic            clk = 1'b0;
   logic            ctr_nrst = 1'b1;
   logic            sclk, mosi, miso;
   logic            miso_drv = 1'b0;
   logic            loop = 1'b0;
   logic [N_SS-1:0] ss;

   int n_chk  = 0;
   int n_fail = 0;

   logic [N_SS-1:0] ss_log   [MAXT];
   logic            sclk_log [MAXT];
   logic            mosi_log [MAXT];
   logic            miso_log [MAXT];

   typedef struct {
      logic        cpha;
      logic        cpol;
      logic        lsb;
      int          idx;
      int          div;
      int          len;
      logic [31:0] tx;
      int          mmode;   // 0 loopback, 1 constant 1, 2 random
      logic [31:0] rx_req;
      int          ss_low;
   } vec_t;

   vec_t tbl [5];

   spi_master_cfg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   spi_master_cfg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SS(N_SS), .DIV_W(8)) dut (
      .clk      (clk),
      .ctr_nrst (ctr_nrst),
      .sclk     (sclk),
      .ss       (ss),
      .mosi     (mosi),
      .miso     (miso),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   assign miso = loop ? mosi : miso_drv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic bus_wr(input int a, input logic [31:0] d);
      @(negedge clk);
      bus.address = 3'(a); bus.data_in = d; bus.we = 1'b1; bus.sel = 1'b1;
      @(negedge clk);
      bus.we = 1'b0; bus.sel = 1'b0;
   endtask

   task automatic bus_rd(input int a, output logic [31:0] d);
      @(negedge clk);
      bus.address = 3'(a); bus.we = 1'b0; bus.sel = 1'b1;
      #1 d = bus.data_out;
      @(negedge clk);
      bus.sel = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      logic [31:0] rd;
      int k;
      for (k = 0; k < bound; k++) begin
         bus_rd(1, rd);
         if (rd[1] == 1'b0) break;
      end
      chk("wait_idle_in_budget", 64'(k < bound), 64'(1));
   endtask

   function automatic logic drive_miso(input int mmode);
      if (mmode == 1) return 1'b1;
      if (mmode == 2) return 1'($urandom);
      return 1'b0;
   endfunction

   // One full transfer: configure, log every cycle, then compare to the model
   task automatic xfer(input logic cpha, input logic cpol, input logic lsb,
                       input int idx, input int div, input int len,
                       input logic [31:0] tx, input int mmode,
                       input logic use_tbl, input logic [31:0] rx_req, input int ss_req);
      int hp, n, tend, e, j, k;
      int errs_ss, errs_sclk, errs_mosi, nedge, nlow;
      logic [N_SS-1:0] one, exp_ss;
      logic [31:0] rx_m, rd;
      hp = div + 1; n = len + 1; tend = (2 * n + 1) * hp;
      one = 4'b0001;
      loop = (mmode == 0);
      bus_wr(4, {27'b0, 2'(idx), lsb, cpol, cpha});
      bus_wr(5, 32'(div));
      bus_wr(6, 32'(len));
      @(negedge clk);
      bus.address = 3'd2; bus.data_in = tx; bus.we = 1'b1; bus.sel = 1'b1;
      miso_drv = drive_miso(mmode);
      #1 miso_log[0] = miso;
      @(posedge clk); #1;
      ss_log[0] = ss; sclk_log[0] = sclk; mosi_log[0] = mosi;
      for (int t = 1; t <= tend + 1; t++) begin
         @(negedge clk);
         bus.we = 1'b0; bus.sel = 1'b0;
         miso_drv = drive_miso(mmode);
         #1 miso_log[t] = miso;
         @(posedge clk); #1;
         ss_log[t] = ss; sclk_log[t] = sclk; mosi_log[t] = mosi;
      end
      errs_ss = 0; errs_sclk = 0; errs_mosi = 0; nedge = 0; nlow = 0;
      for (int t = 0; t <= tend + 1; t++) begin
         e = t / hp;
         if (e > 2 * n) e = 2 * n;
         exp_ss = (t < tend) ? ~(one << idx) : '1;
         if (ss_log[t] !== exp_ss) errs_ss++;
         if (ss_log[t] !== 4'hF) nlow++;
         if (sclk_log[t] !== (cpol ^ 1'(e % 2))) errs_sclk++;
         if (t >= tend) begin
            if (mosi_log[t] !== 1'b0) errs_mosi++;
         end else if (!(cpha && e == 0)) begin
            j = cpha ? (e - 1) / 2 : ((e / 2 < n - 1) ? e / 2 : n - 1);
            if (mosi_log[t] !== tx[lsb ? j : len - j]) errs_mosi++;
         end
         if (t > 0 && sclk_log[t] !== sclk_log[t-1]) nedge++;
      end
      rx_m = '0;
      for (int m = 0; m < n; m++) begin
         k = cpha ? 2 * m + 2 : 2 * m + 1;
         rx_m[lsb ? m : len - m] = miso_log[k * hp];
      end
      chk("ss_window", 64'(errs_ss), 64'(0));
      chk("sclk_wave", 64'(errs_sclk), 64'(0));
      chk("mosi_wave", 64'(errs_mosi), 64'(0));
      chk("edge_count", 64'(nedge), 64'(2 * n));
      bus_rd(1, rd);
      chk("status_done", 64'(rd), 64'(1));
      bus_rd(3, rd);
      chk("rx_model", 64'(rd), 64'(rx_m));
      if (use_tbl) begin
         chk("rx_table", 64'(rd), 64'(rx_req));
         chk("ss_low_cycles", 64'(nlow), 64'(ss_req));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 1,   7,  32'hA5,       0, 32'hA5,       34};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 2, 0,   3,  32'h6,        1, 32'hF,        9};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 3, 2,   15, 32'h1234,     0, 32'h1234,     99};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1, 0,   0,  32'h1,        0, 32'h1,        3};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 255, 31, 32'hDEADBEEF, 0, 32'hDEADBEEF, 16640};

      bus.data_in = '0; bus.address = 3'd1; bus.we = 1'b0; bus.sel = 1'b0;
      #1 ctr_nrst = 1'b0;
      #11;
      chk("rst_ss", 64'(ss), 64'(4'hF));
      chk("rst_sclk", 64'(sclk), 64'(0));
      chk("rst_mosi", 64'(mosi), 64'(0));
      chk("rst_irq", 64'(bus.interrupt), 64'(0));
      chk("rst_status", 64'(bus.data_out), 64'(0));
      @(negedge clk) ctr_nrst = 1'b1;
      bus_rd(6, rd); chk("rst_len", 64'(rd), 64'(DATA_W - 1));
      bus_rd(5, rd); chk("rst_div", 64'(rd), 64'(0));
      bus_rd(4, rd); chk("rst_cfg", 64'(rd), 64'(0));
      bus_rd(3, rd); chk("rst_rx", 64'(rd), 64'(0));

      for (int i = 0; i < 5; i++)
         xfer(tbl[i].cpha, tbl[i].cpol, tbl[i].lsb, tbl[i].idx, tbl[i].div, tbl[i].len,
              tbl[i].tx, tbl[i].mmode, 1'b1, tbl[i].rx_req, tbl[i].ss_low);

      // TX write while busy: err set, transfer and busy-time writes untouched
      loop = 1'b1;
      bus_wr(4, 32'h0); bus_wr(5, 32'd1); bus_wr(6, 32'd7);
      bus_wr(2, 32'hA5);
      bus_wr(2, 32'h3C);
      bus_wr(5, 32'd7);
      bus_rd(1, rd); chk("busy_status", 64'(rd), 64'(3'b110));
      wait_idle(200);
      bus_rd(1, rd); chk("busy_status_after", 64'(rd), 64'(3'b001));
      bus_rd(5, rd); chk("busy_div_kept", 64'(rd), 64'(1));
      bus_rd(3, rd); chk("busy_rx", 64'(rd), 64'(32'hA5));

      // Interrupt follows int_en & ready
      loop = 1'b0; miso_drv = 1'b1;
      bus_wr(0, 32'h1);
      bus_wr(4, 32'h1); bus_wr(5, 32'd0); bus_wr(6, 32'd4);
      bus_wr(2, 32'h15);
      wait_idle(100);
      #1 chk("irq_set", 64'(bus.interrupt), 64'(1));
      bus_wr(0, 32'h0);
      #1 chk("irq_masked", 64'(bus.interrupt), 64'(0));
      bus_wr(0, 32'h1);
      #1 chk("irq_unmasked", 64'(bus.interrupt), 64'(1));
      bus_rd(3, rd);
      chk("irq_rx", 64'(rd), 64'(32'h1F));
      #1 chk("irq_cleared", 64'(bus.interrupt), 64'(0));

      // Randomized transfers against the model
      for (int r = 0; r < 20; r++)
         xfer(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom,
              int'($urandom_range(0, 2)), 1'b0, 32'h0, 0);

      // Reset asserted mid-transfer
      loop = 1'b1;
      bus_wr(4, 32'h0); bus_wr(5, 32'd3); bus_wr(6, 32'd7);
      bus_wr(2, 32'hFF);
      repeat (12) @(negedge clk);
      #2 ctr_nrst = 1'b0;
      #1;
      chk("midrst_ss", 64'(ss), 64'(4'hF));
      chk("midrst_sclk", 64'(sclk), 64'(0));
      chk("midrst_mosi", 64'(mosi), 64'(0));
      @(negedge clk) ctr_nrst = 1'b1;
      bus_rd(1, rd); chk("midrst_status", 64'(rd), 64'(0));
      bus_rd(6, rd); chk("midrst_len", 64'(rd), 64'(DATA_W - 1));
      bus_rd(3, rd); chk("midrst_rx", 64'(rd), 64'(0));
      repeat (40) @(negedge clk);
      chk("midrst_stays_idle", 64'(ss), 64'(4'hF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: control data width and maximum transfer length in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: control address width.
REQ-003 SHALL have parameter N_SS, default 4: number of slave-select lines.
REQ-004 SHALL have parameter DIV_W, default 8: width of the clock-divider register.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 SHALL have port ctr_nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port sclk, output, 1 bit: SPI clock, generated internally from clk.
REQ-008 SHALL have port ss, output, N_SS bits: active-low slave selects.
REQ-009 SHALL have port mosi, output, 1 bit: master out, slave in.
REQ-010 SHALL have port miso, input, 1 bit: master in, slave out.
REQ-011 SHALL have port data_in, input, DATA_W bits: control write data.
REQ-012 SHALL have port data_out, output, DATA_W bits: control read data, combinational from address.
REQ-013 SHALL have port address, input, ADDR_W bits: register select.
REQ-014 SHALL have ports we and sel, inputs, 1 bit each: write strobe and access select.
REQ-015 SHALL have port interrupt, output, 1 bit: int_en AND ready.

Function
REQ-016 SHALL decode the register map as follows:
- 0 INTRRPT_EN: W bit0.
- 1 STATUS: R {err, busy, ready} in bits 2:0; a read (sel&~we) clears err.
- 2 TX: W loads tx data and starts a transfer.
- 3 RX: R returns rx data; a read clears ready.
- 4 CONFIG: R/W; [0] CPHA, [1] CPOL, [2] lsb_first, [3+:clog2(N_SS)] ss index.
- 5 DIV: R/W; half-period = DIV+1 clk cycles.
- 6 LEN: R/W, clog2(DATA_W) bits; bit count = LEN+1.
- Other addresses: read 0, write ignored.
REQ-017 SHALL implement FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE; busy=1 in every state except IDLE.
REQ-018 SHALL, on a TX write in IDLE at posedge T, enter SETUP at T+1, drive ss[index]=0 (other ss bits 1), and clear ready.
REQ-019 SHALL produce sclk edge k (k=1..2(LEN+1)) exactly k*(DIV+1) clk cycles after ss assertion; sclk idles at CPOL.
REQ-020 SHALL deassert ss, enter IDLE and set ready exactly (2(LEN+1)+1)*(DIV+1) cycles after ss assertion.
REQ-021 SHALL, with CPHA=0, present the first bit on mosi at ss assertion, sample miso on odd edges and shift mosi on even edges except the last.
REQ-022 SHALL, with CPHA=1, shift mosi on odd edges (first bit at edge 1) and sample miso on even edges.
REQ-023 SHALL send tx[LEN] down to tx[0] when lsb_first=0, and tx[0] up to tx[LEN] when lsb_first=1.
REQ-024 SHALL right-justify rx: received bit i goes to rx[i] in transmit-bit order; bits above LEN read 0.
REQ-025 SHALL ignore TX, CONFIG, DIV and LEN writes while busy; a TX write while busy SHALL set err.
REQ-026 SHALL, when a TX start and an RX read coincide, give the start priority (ready=0).
REQ-027 SHALL hold mosi=0 in IDLE.

Reset
REQ-028 SHALL, on ctr_nrst=0, set asynchronously: state IDLE, ss all 1, sclk 0, mosi 0, ready 0, err 0, int_en 0, CONFIG 0, DIV 0, LEN DATA_W-1, rx 0, interrupt 0.
REQ-029 SHALL abort any transfer in progress when reset is asserted, with no ready and no partial rx retained.

Verification
REQ-030 SHALL verify mode 0, msb, DIV=1, LEN=7, TX=0xA5, miso looped to mosi -> ss[0] low 34 cycles; 8 rising sclk edges; RX=0x000000A5; ready=1.
REQ-031 SHALL verify mode 3, lsb_first, index 2, DIV=0, LEN=3, TX=0x6, miso=1 -> only ss[2] low 9 cycles; sclk idles 1; mosi sequence 0,1,1,0; RX=0xF.
REQ-032 SHALL verify a TX write during busy -> transfer unchanged; STATUS=0b110; after STATUS read and completion, STATUS=0b001.
REQ-033 SHALL verify int_en=1 with a transfer completed -> interrupt=1; after an RX read, interrupt=0 on the next cycle.
REQ-034 SHALL verify ctr_nrst pulsed mid-XFER -> ss=all 1, sclk=0, STATUS=0, LEN reads DATA_W-1.
REQ-035 SHALL verify LEN=DATA_W-1, DIV=255 -> exactly 2*DATA_W edges, each 256 cycles apart, with no counter wrap.
